// File: rtl/id_ex_reg_pkg.sv
// Shared processor definitions: ALUOp encodings, opcode width and the
// control bundle carried from ID to EX.
package id_ex_reg_pkg;

  localparam int OPCODE_W  = 11;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    valid;
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // An invalid slot must never write registers or memory, so its whole
  // control bundle (including ALUOp) collapses to the bubble value.
  function automatic ctrl_t gate_ctrl(input ctrl_t c);
    ctrl_t r;
    r = c.valid ? c : CTRL_BUBBLE;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Parameterized pipeline register: async active-low reset, synchronous
// clear (wins over enable) and load enable.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and a
// saturating count of stalled cycles. All outputs come straight from flops.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic [DATA_W-1:0]    id_rd1,
  input  logic [DATA_W-1:0]    id_rd2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [OPCODE_W-1:0]  id_opcode,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [1:0]           id_alu_op,
  input  logic                 id_alu_src,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_mem_to_reg,
  input  logic                 id_reg_write,
  input  logic                 id_branch,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [DATA_W-1:0]    ex_rd1,
  output logic [DATA_W-1:0]    ex_rd2,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [OPCODE_W-1:0]  ex_opcode,
  output logic [REG_IDX_W-1:0] ex_rn,
  output logic [REG_IDX_W-1:0] ex_rm,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [1:0]           ex_alu_op,
  output logic                 ex_alu_src,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic                 ex_reg_write,
  output logic                 ex_branch,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int DP_W   = 4 * DATA_W + OPCODE_W + 3 * REG_IDX_W;
  localparam int CTRL_W = $bits(ctrl_t);

  logic              load_en;
  logic [DP_W-1:0]   dp_d;
  logic [DP_W-1:0]   dp_q;
  ctrl_t             ctrl_raw;
  ctrl_t             ctrl_d;
  logic [CTRL_W-1:0] ctrl_q_bits;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;

  // Flush clears both bundles through the sync clear, so it overrides stall.
  assign load_en = ~stall;

  assign dp_d = {id_pc, id_rd1, id_rd2, id_imm, id_opcode, id_rn, id_rm, id_rd};

  always_comb begin
    ctrl_raw            = CTRL_BUBBLE;
    ctrl_raw.valid      = id_valid;
    ctrl_raw.alu_op     = alu_op_e'(id_alu_op);
    ctrl_raw.alu_src    = id_alu_src;
    ctrl_raw.mem_read   = id_mem_read;
    ctrl_raw.mem_write  = id_mem_write;
    ctrl_raw.mem_to_reg = id_mem_to_reg;
    ctrl_raw.reg_write  = id_reg_write;
    ctrl_raw.branch     = id_branch;
    ctrl_d              = gate_ctrl(ctrl_raw);
  end

  pipe_reg #(.W(DP_W)) u_dp_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (flush),
    .d     (dp_d),
    .q     (dp_q)
  );

  pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (flush),
    .d     (ctrl_d),
    .q     (ctrl_q_bits)
  );

  assign ctrl_q = ctrl_t'(ctrl_q_bits);

  assign {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_opcode, ex_rn, ex_rm, ex_rd} = dp_q;

  assign ex_valid      = ctrl_q.valid;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_branch     = ctrl_q.branch;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a behavioural model predicts each cycle's
// outputs into a queue, which is popped and compared after the clock edge.
module tb_id_ex_reg;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, id_valid;
  logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [10:0]   id_opcode;
  logic [4:0]    id_rn, id_rm, id_rd;
  logic [1:0]    id_alu_op;
  logic          id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch;
  logic          ex_valid;
  logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [10:0]   ex_opcode;
  logic [4:0]    ex_rn, ex_rm, ex_rd;
  logic [1:0]    ex_alu_op;
  logic          ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch;
  logic [CW-1:0] stall_cnt;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [10:0]   opc;
    logic [4:0]    rn, rm, rd;
    logic [1:0]    aluop;
    logic [5:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_opcode(id_opcode), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_branch(id_branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_opcode(ex_opcode), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
    chk({tag, ".pc"},    ex_pc,  e.pc);
    chk({tag, ".rd1"},   ex_rd1, e.rd1);
    chk({tag, ".rd2"},   ex_rd2, e.rd2);
    chk({tag, ".imm"},   ex_imm, e.imm);
    chk({tag, ".opc"},   64'(ex_opcode), 64'(e.opc));
    chk({tag, ".regs"},  64'({ex_rn, ex_rm, ex_rd}), 64'({e.rn, e.rm, e.rd}));
    chk({tag, ".aluop"}, 64'(ex_alu_op), 64'(e.aluop));
    chk({tag, ".ctl"},   64'({ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                              ex_reg_write, ex_branch}), 64'(e.ctl));
    chk({tag, ".cnt"},   64'(stall_cnt), 64'(e.cnt));
  endtask

  task automatic set_instr(input logic v, input logic [10:0] opc, input logic [1:0] aop,
                           input logic [5:0] ctl, input logic [63:0] pc,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm);
    id_valid = v; id_opcode = opc; id_alu_op = aop;
    {id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch} = ctl;
    id_pc = pc; id_rd1 = a; id_rd2 = b; id_imm = imm;
    id_rn = opc[4:0]; id_rm = pc[6:2]; id_rd = a[4:0];
  endtask

  function automatic exp_t model_next(input exp_t cur, input logic st, input logic fl);
    exp_t n;
    n = cur;
    if (fl) begin
      n = '0;
      n.cnt = cur.cnt;
    end else if (st) begin
      if (cur.cnt != {CW{1'b1}}) n.cnt = cur.cnt + 1'b1;
    end else begin
      n.valid = id_valid;
      n.pc = id_pc; n.rd1 = id_rd1; n.rd2 = id_rd2; n.imm = id_imm;
      n.opc = id_opcode; n.rn = id_rn; n.rm = id_rm; n.rd = id_rd;
      n.aluop = id_valid ? id_alu_op : 2'b00;
      n.ctl = id_valid ? {id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg,
                          id_reg_write, id_branch} : 6'b0;
    end
    return n;
  endfunction

  task automatic cycle(input string tag, input logic st, input logic fl);
    exp_t e;
    stall = st; flush = fl;
    m = model_next(m, st, fl);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_all(tag, e);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    m = '0;
    exp_q.delete();
    #1;
    chk_all(tag, m);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 11'd0, 2'b00, 6'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    m = '0;
    #1 rst_n = 1'b0;
    #2 chk_all("reset", m);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD capture, then async reset while ex_reg_write=1
    set_instr(1'b1, 11'b10001011000, 2'b10, 6'b000010, 64'h100, 64'd5, 64'd7, 64'd0);
    cycle("add", 1'b0, 1'b0);
    chk("add.regwr_set", 64'(ex_reg_write), 64'd1);
    async_reset("rst_mid");

    // SUB captured, then three stalls with ORR on the inputs
    set_instr(1'b1, 11'b11001011000, 2'b10, 6'b000010, 64'h104, 64'd9, 64'd3, 64'd0);
    cycle("sub", 1'b0, 1'b0);
    set_instr(1'b1, 11'b10101010000, 2'b10, 6'b000010, 64'h108, 64'd1, 64'd2, 64'd0);
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0);
    chk("stall.opc_held", 64'(ex_opcode), 64'b11001011000);
    chk("stall.cnt3", 64'(stall_cnt), 64'd3);
    cycle("orr", 1'b0, 1'b0);

    // LDUR with stall and flush together: flush wins, count unchanged
    set_instr(1'b1, 11'b11111000010, 2'b00, 6'b110110, 64'h10c, 64'h2000, 64'd0, 64'd16);
    cycle("flush_pri", 1'b1, 1'b1);
    chk("flush.cnt_keep", 64'(stall_cnt), 64'd3);

    // Invalid CBZ must not write memory
    set_instr(1'b0, 11'b10110100000, 2'b01, 6'b001001, 64'h110, 64'd0, 64'd0, 64'h40);
    cycle("invalid", 1'b0, 1'b0);

    // Reset during a stall discards the held contents
    set_instr(1'b1, 11'b10001011000, 2'b10, 6'b000010, 64'h200, 64'd11, 64'd12, 64'd0);
    cycle("pre_stall", 1'b0, 1'b0);
    cycle("st_a", 1'b1, 1'b0);
    cycle("st_b", 1'b1, 1'b0);
    async_reset("rst_stall");
    set_instr(1'b1, 11'b11111000000, 2'b00, 6'b101000, 64'h300, 64'd21, 64'd22, 64'd8);
    cycle("post_rst", 1'b0, 1'b0);

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      set_instr(1'($urandom_range(0, 3) != 0), 11'($urandom), 2'($urandom_range(0, 2)),
                6'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom});
      cycle("rand", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0));
    end

    // Saturation of the 4-bit counter
    async_reset("rst_sat");
    for (int i = 0; i < 20; i++) cycle("sat", 1'b1, 1'b0);
    chk("sat.cnt15", 64'(stall_cnt), 64'd15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of datapath operands and PC.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall-cycle counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  hold current contents (hazard unit).
REQ-007 flush  input  1  replace next contents with a bubble (branch taken).
REQ-008 id_valid  input  1  ID stage holds a real instruction.
REQ-009 id_pc, id_rd1, id_rd2, id_imm  input  DATA_W each  PC, register reads, sign-extended immediate.
REQ-010 id_opcode  input  11  instruction[31:21].
REQ-011 id_rn, id_rm, id_rd  input  5 each  register indices.
REQ-012 id_alu_op  input  2  ALUOp (00 load/store add, 01 CBZ pass-B, 10 R-type decode).
REQ-013 id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch  input  1 each  control bits.
REQ-014 ex_* outputs  output  same widths  registered copies of every id_* input, plus ex_valid.
REQ-015 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-016 SHALL capture all id_* inputs into ex_* on rising clk when stall=0 and flush=0; latency exactly 1 cycle.
REQ-017 SHALL hold every ex_* output unchanged when stall=1 and flush=0.
REQ-018 SHALL, when flush=1, load a bubble: ex_valid=0, ex_alu_op=00, all six control bits 0; datapath fields (pc, rd1, rd2, imm, opcode, rn, rm, rd) zeroed.
REQ-019 flush SHALL take priority over stall when both are 1 in the same cycle.
REQ-020 SHALL force control bits and ex_alu_op to 0 on capture when id_valid=0, so an invalid instruction never writes registers or memory.
REQ-021 ex_opcode and ex_alu_op SHALL always be consistent (from the same captured instruction) to feed ALU control combinationally.
REQ-022 stall_cnt SHALL increment by 1 on each rising edge with stall=1 and flush=0, saturating at all-ones.
REQ-023 stall_cnt SHALL not change on flush or normal capture.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force all ex_* outputs to 0 (ex_valid=0, ex_alu_op=00) and stall_cnt to 0.
REQ-026 Reset asserted mid-stall SHALL discard held contents; first capture after deassertion SHALL follow REQ-016 to REQ-019.
REQ-027 Reset deassertion SHALL be synchronized externally; the block adds no synchronizer.

Structure
REQ-028 ALUOp encodings (ALUOP_MEM=00, ALUOP_CBZ=01, ALUOP_RTYPE=10), the opcode width (11) and a packed control-bundle typedef SHALL reside in the shared processor package.
REQ-029 One sub-module is natural: pipe_reg, a parameterized-width register with async active-low reset, enable, and synchronous clear, instantiated for the datapath and control bundles.
REQ-030 stall_cnt logic SHALL live in id_ex_reg, not in pipe_reg.

Verification
REQ-031 Reset: rst_n=0 mid-cycle with ex_reg_write=1 -> all outputs 0 before next edge, stall_cnt=0.
REQ-032 Capture: id_opcode=10001011000 (ADD), id_alu_op=10, id_reg_write=1, id_rd1=5, id_rd2=7 -> next cycle ex_opcode=10001011000, ex_alu_op=10, ex_rd1=5, ex_rd2=7, ex_valid=1.
REQ-033 Stall: capture SUB 11001011000, then stall=1 for 3 cycles while inputs show ORR 10101010000 -> ex_opcode stays 11001011000, stall_cnt=3; release -> ex_opcode=10101010000 next cycle.
REQ-034 Flush priority: LDUR 11111000010, alu_op=00, mem_read=1 with stall=1 and flush=1 -> ex_valid=0, ex_mem_read=0, ex_alu_op=00, ex_opcode=0, stall_cnt unchanged.
REQ-035 Invalid: id_valid=0, id_mem_write=1, id_alu_op=01, id_opcode=10110100000 (CBZ) -> ex_mem_write=0, ex_alu_op=00, ex_valid=0.
REQ-036 Saturation: CNT_W=4, stall held 20 cycles -> stall_cnt reaches 15 and holds at 15.
